// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, one-cycle imem latency absorber, 2-entry output FIFO
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [63:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    logic [63:0] pc_q;
    logic [63:0] req_pc_q;
    logic        req_valid_q;
    logic [1:0]  occ;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [63:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  level;
    logic        unused_bits;

    assign imem_addr   = {2'b00, pc_q[63:2]};
    assign out_valid   = (occ != 2'd0);
    assign out_pc      = fifo_pc[rd_ptr];
    assign out_instr   = fifo_instr[rd_ptr];
    assign unused_bits = ^{imem_data[63:32], redirect_pc[1:0]};

    // A redirect kills both the pop and the arriving response.
    assign pop   = out_valid & out_ready & ~redirect_valid;
    assign push  = req_valid_q & ~redirect_valid;
    // Occupancy once the in-flight response lands; issuing only below 2
    // guarantees that response always has a free slot.
    assign level = {1'b0, occ} + {2'b00, req_valid_q} - {2'b00, pop};
    assign issue = ~redirect_valid & (level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 64'h0;
            req_valid_q <= 1'b0;
            occ         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 64'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            pc_q        <= {redirect_pc[63:2], 2'b00};
            req_valid_q <= 1'b0;
            occ         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            req_valid_q <= issue;
            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 64'd4;
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc_q;
                fifo_instr[wr_ptr] <= imem_data[31:0];
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit (word i holds 0x1000+i)
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [63:0] imem_data = 64'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_pops = 0;
    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; upper half is junk the DUT must ignore.
    always @(posedge clk) begin
        imem_data <= {32'hDEAD_BEEF, 32'(imem_addr + 64'h1000)};
    end

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'((pc >> 2) + 64'h1000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(start + 64'(4 * i));
        end
    endtask

    // Scoreboard: every accepted output must match the next expected pc.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_out", {63'b0, out_valid}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_out_pc", out_pc, e);
                chk("sb_out_instr", {32'b0, out_instr}, {32'b0, instr_of(e)});
                n_pops++;
            end
        end
    end

    task automatic release_and_check_startup(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        load_stream(64'h0);
        cyc();
        @(negedge clk);
        chk({tag, "_valid_e1"}, {63'b0, out_valid}, 64'd0);
        cyc();
        @(negedge clk);
        chk({tag, "_valid_e2"}, {63'b0, out_valid}, 64'd1);
        chk({tag, "_pc_e2"}, out_pc, 64'h0);
        chk({tag, "_instr_e2"}, {32'b0, out_instr}, 64'h1000);
    endtask

    initial begin
        logic [63:0] addr0, pc0;
        logic [31:0] ins0;
        int          p0;

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_instr", {32'b0, out_instr}, 64'h0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        redirect_valid = 1'b0;
        release_and_check_startup("start");

        // Full-rate streaming.
        cyc();
        p0 = n_pops;
        repeat (8) cyc();
        chk("throughput", 64'(n_pops - p0), 64'd8);

        // Back-pressure: outputs and fetch address freeze.
        out_ready = 1'b0;
        @(negedge clk);
        addr0 = imem_addr;
        pc0   = out_pc;
        ins0  = out_instr;
        repeat (5) begin
            cyc();
            @(negedge clk);
        end
        chk("stall_imem_addr", imem_addr, addr0);
        chk("stall_out_pc", out_pc, pc0);
        chk("stall_out_instr", {32'b0, out_instr}, {32'b0, ins0});
        chk("stall_valid", {63'b0, out_valid}, 64'd1);
        cyc();
        out_ready = 1'b1;
        repeat (6) cyc();

        // Redirect while the FIFO is full.
        out_ready = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h43;
        load_stream(64'h40);
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk("redir_t1_valid", {63'b0, out_valid}, 64'd0);
        cyc();
        @(negedge clk);
        chk("redir_t2_valid", {63'b0, out_valid}, 64'd0);
        cyc();
        @(negedge clk);
        chk("redir_t3_valid", {63'b0, out_valid}, 64'd1);
        chk("redir_t3_pc", out_pc, 64'h40);
        chk("redir_t3_instr", {32'b0, out_instr}, 64'h1010);

        // Redirect coinciding with a pop and a request in flight.
        repeat (4) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        load_stream(64'h200);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redpop_t1_valid", {63'b0, out_valid}, 64'd0);
        cyc();
        cyc();
        @(negedge clk);
        chk("redpop_first_pc", out_pc, 64'h200);

        // PC wrap-around.
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        load_stream(64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr_top", imem_addr, 64'h3FFF_FFFF_FFFF_FFFF);
        cyc();
        @(negedge clk);
        chk("wrap_addr_zero", imem_addr, 64'h0);
        cyc();
        @(negedge clk);
        chk("wrap_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_pc_zero", out_pc, 64'h0);

        // Asynchronous reset between clock edges.
        repeat (3) cyc();
        #2;
        chk("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_pc", out_pc, 64'h0);
        chk("arst_instr", {32'b0, out_instr}, 64'h0);
        chk("arst_imem_addr", imem_addr, 64'h0);
        repeat (2) cyc();
        release_and_check_startup("restart");
        cyc();
        p0 = n_pops;
        repeat (6) cyc();
        chk("restart_throughput", 64'(n_pops - p0), 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
